// File: rtl/sprite_position_serializer.sv
// sprite_position_serializer: valid/ready request in (in_valid/in_ready, load_x/y, pos_x/y, abort), MSB-first strobed serial x/y lanes out (shift_x/data_x, shift_y/data_y) with a done pulse
module sprite_position_serializer #(
  parameter int POS_WIDTH  = 8,
  parameter int BIT_PERIOD = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 load_x,
  input  logic                 load_y,
  input  logic [POS_WIDTH-1:0] pos_x,
  input  logic [POS_WIDTH-1:0] pos_y,
  input  logic                 abort,
  output logic                 shift_x,
  output logic                 data_x,
  output logic                 shift_y,
  output logic                 data_y,
  output logic                 done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam int BW = POS_WIDTH > 1 ? $clog2(POS_WIDTH) : 1;
  localparam int CW = BIT_PERIOD > 1 ? $clog2(BIT_PERIOD) : 1;
  logic [1:0]           state_q, state_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [POS_WIDTH-1:0] sx_q, sx_d, sy_q, sy_d;
  logic                 lx_q, lx_d, ly_q, ly_d;
  logic                 ready_q, sfx_q, dx_q, sfy_q, dy_q, done_q;
  logic                 accept, strobe;
  assign accept   = state_q == IDLE && in_valid && ready_q;
  assign in_ready = ready_q;
  assign shift_x  = sfx_q;
  assign data_x   = dx_q;
  assign shift_y  = sfy_q;
  assign data_y   = dy_q;
  assign done     = done_q;
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    lx_d    = lx_q;
    ly_d    = ly_q;
    if (state_q == IDLE) begin
      if (accept) begin
        sx_d    = pos_x;
        sy_d    = pos_y;
        lx_d    = load_x;
        ly_d    = load_y;
        state_d = (load_x || load_y) ? SHIFT : DONE;
        bit_d   = BW'(POS_WIDTH - 1);
        cnt_d   = '0;
      end
    end else if (state_q == SHIFT) begin
      if (abort) begin
        state_d = IDLE;
      end else if (cnt_q == CW'(BIT_PERIOD - 1)) begin
        cnt_d   = '0;
        state_d = bit_q == '0 ? DONE : SHIFT;
        bit_d   = bit_q == '0 ? bit_q : bit_q - 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      state_d = IDLE;
    end
  end
  // Outputs are registered from the next state so the first strobe lands in the cycle right after accept
  assign strobe = state_d == SHIFT && cnt_d == '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      cnt_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      lx_q    <= 1'b0;
      ly_q    <= 1'b0;
      ready_q <= 1'b0;
      sfx_q   <= 1'b0;
      dx_q    <= 1'b0;
      sfy_q   <= 1'b0;
      dy_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      ready_q <= state_d == IDLE;
      sfx_q   <= strobe && lx_d;
      dx_q    <= strobe && lx_d && sx_d[bit_d];
      sfy_q   <= strobe && ly_d;
      dy_q    <= strobe && ly_d && sy_d[bit_d];
      done_q  <= state_d == DONE;
    end
  end
endmodule

// File: doc/sprite_position_serializer.md
Name: sprite_position_serializer

Overview:
- Transmit end of the bit-serial sprite position load interface.
- Accepts a parallel x/y position request through a valid/ready handshake and replays it as MSB-first shift strobes with data bits on two independent lanes (x, y).
- After 8 strobes on a lane, a downstream shift-register receiver (new = {old[6:0], bit}) holds exactly the requested value.
- Sits between the host/config logic and the sprite position registers.

Parameters:
POS_WIDTH, 8, bits per position word; also the strobe count per lane.
BIT_PERIOD, 1, clock cycles per serial bit; must be >= 1. Strobe is high in the first cycle of each period.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
load_x  input  1  request includes x lane; sampled on accept
load_y  input  1  request includes y lane; sampled on accept
pos_x  input  POS_WIDTH  x position to send; sampled on accept
pos_y  input  POS_WIDTH  y position to send; sampled on accept
abort  input  1  synchronous cancel of the transfer in progress
shift_x  output  1  x lane shift strobe
data_x  output  1  x lane serial bit; valid when shift_x=1
shift_y  output  1  y lane shift strobe
data_y  output  1  y lane serial bit; valid when shift_y=1
done  output  1  one-cycle pulse when a transfer completes

Behaviour:
- All outputs are registered.
- While reset is high and in the cycle it is released: shift_x=shift_y=data_x=data_y=done=0, in_ready=0, FSM=IDLE. in_ready rises one cycle after reset deasserts.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - Accept happens when in_valid && in_ready at a clock edge. On accept, pos_x, pos_y, load_x and load_y are latched into shadow registers.
  - If load_x=load_y=0: accept, no strobes, done=1 next cycle, state goes to DONE.
  - Otherwise: state goes to SHIFT, bit index = POS_WIDTH-1, period counter = 0.
- SHIFT:
  - in_ready=0.
  - Bit period: in a cycle where the period counter = 0, shift_<lane>=1 for each latched lane, and data_<lane> = shadow[bit index]. All other cycles: shift=0, data=0.
  - Lane handling: x and y strobe in the same cycles. A lane not requested keeps shift=0 and data=0 for the whole transfer.
  - Counters: the period counter wraps at BIT_PERIOD-1. The bit index decrements on wrap.
  - After the strobe for bit 0, the remaining BIT_PERIOD-1 idle cycles elapse, then state goes to DONE.
- Timing: first strobe in the first cycle after the accept edge. Bit i (counting from MSB, i=0..POS_WIDTH-1) strobes at accept+1+i*BIT_PERIOD. The transfer occupies POS_WIDTH*BIT_PERIOD cycles.
- DONE: done=1, in_ready=0, no strobes; exactly one cycle, then IDLE.
- Back-to-back requests: the minimum spacing between accepts is POS_WIDTH*BIT_PERIOD+2 cycles.
- abort:
  - Sampled in SHIFT. When high at an edge, the state goes to IDLE. From the next cycle: no further strobes, done stays 0, shadow registers are left as-is.
  - A strobe issued in the same cycle abort is high still counts; the receiver holds a partially shifted value. Recovery is the requester's responsibility.
  - abort is ignored in IDLE and DONE.
  - abort in the same cycle as an accept is ignored; the accept wins.
- Input stability: inputs other than in_valid/abort may change freely after accept; only the shadow copies are used.
- Reset mid-transfer: strobes stop immediately (asynchronously), the transfer is dropped, and done is not pulsed.

Test Plan:
1. BIT_PERIOD=1, accept pos_x=0xA5, load_x=1, load_y=0 -> shift_x high for 8 consecutive cycles starting accept+1; data_x sequence 1,0,1,0,0,1,0,1; shift_y=0 throughout; done at accept+9; in_ready back at accept+10; model receiver x=0xA5.
2. BIT_PERIOD=3, accept x=0x3C, y=0xC3, both lanes -> strobes at accept+1,+4,…,+22 on both lanes simultaneously; data_x=0,0,1,1,1,1,0,0, data_y complementary; done at accept+25; receiver x=0x3C, y=0xC3.
3. Accept with load_x=load_y=0 -> no strobes; done at accept+1; in_ready=0 at accept+1, 1 at accept+2.
4. in_valid held high continuously, two requests 0x01 then 0xFE on x with BIT_PERIOD=1 -> second accept exactly 10 cycles after the first; receiver x sequence reaches 0x01 then 0xFE; in_ready never high during SHIFT/DONE.
5. BIT_PERIOD=1, x=0xFF, abort high in the cycle of the 3rd strobe -> exactly 3 strobes total, no done pulse, in_ready=1 the following cycle; receiver low 3 bits 1.
6. Assert reset during the 5th strobe cycle -> shift_x/data_x drop to 0 immediately and no done pulse; after release, in_ready rises one cycle later and a fresh request 0x5A completes correctly.
